// File: rtl/step_ctrl_pkg.sv
// Shared state encoding for the pipeline step controller.
// Used by the FSM in the top module and by debug/LED logic.
package step_ctrl_pkg;
  localparam int STATE_W = 3;
  localparam logic [STATE_W-1:0] ST_WAIT   = 3'd0;
  localparam logic [STATE_W-1:0] ST_FETCH  = 3'd1;
  localparam logic [STATE_W-1:0] ST_STEP   = 3'd2;
  localparam logic [STATE_W-1:0] ST_HALTED = 3'd3;
endpackage

// File: rtl/btn_debouncer.sv
// Synchronizes and debounces the active-low board button and
// emits a one-cycle pulse on each accepted press.
module btn_debouncer
  import step_ctrl_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 270000
) (
  input  logic clock,
  input  logic reset,
  input  logic btn,
  output logic press
);

  logic        s1;
  logic        s2;
  logic        level;
  logic [31:0] cnt;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      s1    <= 1'b1;
      s2    <= 1'b1;
      level <= 1'b1;
      cnt   <= '0;
      press <= 1'b0;
    end else begin
      s1    <= btn;
      s2    <= s1;
      press <= 1'b0;
      // any bounce back to the accepted level restarts the count
      if (s2 == level) begin
        cnt <= '0;
      end else if (cnt == 32'(DEBOUNCE_CYCLES - 1)) begin
        cnt   <= '0;
        level <= s2;
        press <= ~s2;
      end else begin
        cnt <= cnt + 32'd1;
      end
    end
  end

endmodule

// File: rtl/pipeline_step_controller.sv
// Generates the single-cycle pipeline step enable (run or button mode).
// Define PIPE_STEP_COUNT_EN to add the 32-bit step_count register/port.
module pipeline_step_controller
  import step_ctrl_pkg::*;
#(
  parameter int WAIT_TIME       = 54000000,
  parameter int DEBOUNCE_CYCLES = 270000
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               run_mode,
  input  logic               btn,
  input  logic               halt,
  input  logic               fetch_ready,
  output logic               fetch_req,
  output logic               step,
  output logic [STATE_W-1:0] state
`ifdef PIPE_STEP_COUNT_EN
  ,
  output logic [31:0]        step_count
`endif
);

  logic        press;
  logic        token;
  logic        take;
  logic [31:0] cnt;

  btn_debouncer #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_deb (
    .clock(clock),
    .reset(reset),
    .btn  (btn),
    .press(press)
  );

  assign fetch_req = (state == ST_FETCH);
  assign step      = (state == ST_STEP);

  // a press arriving this cycle is consumed directly
  assign take = (state == ST_WAIT) && !halt && !run_mode
              && (token || press);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state <= ST_WAIT;
      cnt   <= '0;
      token <= 1'b0;
    end else begin
      token <= !run_mode && !take && (token || press);
      unique case (state)
        ST_WAIT: begin
          if (halt) begin
            state <= ST_HALTED;
          end else if (run_mode) begin
            if (cnt == 32'(WAIT_TIME - 1)) begin
              cnt   <= '0;
              state <= ST_FETCH;
            end else begin
              cnt <= cnt + 32'd1;
            end
          end else begin
            cnt <= '0;
            if (take) state <= ST_FETCH;
          end
        end
        ST_FETCH: begin
          if (fetch_ready) state <= ST_STEP;
        end
        ST_STEP: begin
          state <= halt ? ST_HALTED : ST_WAIT;
        end
        ST_HALTED: begin
          if (!halt) begin
            state <= ST_WAIT;
            cnt   <= '0;
          end
        end
        default: state <= ST_WAIT;
      endcase
    end
  end

`ifdef PIPE_STEP_COUNT_EN
  always_ff @(posedge clock or posedge reset) begin
    if (reset) step_count <= '0;
    else if (step) step_count <= step_count + 32'd1;
  end
`endif

endmodule

// File: tb/tb_pipeline_step_controller.sv
// Self-checking bench for pipeline_step_controller
// (WAIT_TIME=4, DEBOUNCE_CYCLES=3).
module tb_pipeline_step_controller;

  localparam int WT = 4;
  localparam int DB = 3;
  localparam logic [2:0] S_WAIT = 3'd0;
  localparam logic [2:0] S_FETCH = 3'd1;
  localparam logic [2:0] S_STEP = 3'd2;
  localparam logic [2:0] S_HALT = 3'd3;

  logic clock = 1'b0;
  logic reset = 1'b1;
  logic run_mode = 1'b1;
  logic btn = 1'b1;
  logic halt = 1'b0;
  logic fetch_ready = 1'b0;
  logic fetch_req;
  logic step;
  logic [2:0] state;
`ifdef PIPE_STEP_COUNT_EN
  logic [31:0] step_count;
`endif

  pipeline_step_controller #(
    .WAIT_TIME(WT),
    .DEBOUNCE_CYCLES(DB)
  ) dut (
    .clock(clock),
    .reset(reset),
    .run_mode(run_mode),
    .btn(btn),
    .halt(halt),
    .fetch_ready(fetch_ready),
    .fetch_req(fetch_req),
    .step(step),
    .state(state)
`ifdef PIPE_STEP_COUNT_EN
    ,
    .step_count(step_count)
`endif
  );

  always #5 clock = ~clock;

  int n_chk = 0;
  int n_fail = 0;
  int nsteps = 0;

  always @(posedge clock) if (step === 1'b1) nsteps++;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    @(negedge clock);
    @(negedge clock);
    reset = 1'b0;
  endtask

  task automatic first_step(output int cyc);
    cyc = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clock);
      cyc++;
      if (step) break;
    end
  endtask

  task automatic press_btn(input int low, input int high);
    btn = 1'b0;
    repeat (low) @(negedge clock);
    btn = 1'b1;
    repeat (high) @(negedge clock);
  endtask

  typedef struct {
    logic rm;
    logic h;
    logic fr;
    logic [2:0] st;
    logic freq;
    logic stp;
  } vec_t;

  vec_t tbl[16];

  // reference model: countdown of idle cycles plus phase flags
  int  m_left;
  bit  m_fetching, m_firing, m_stopped;
  int  m_steps;

  function automatic void m_init();
    m_left = WT;
    m_fetching = 0;
    m_firing = 0;
    m_stopped = 0;
    m_steps = 0;
  endfunction

  function automatic void m_advance(input bit h, input bit fr);
    if (m_stopped) begin
      if (!h) begin
        m_stopped = 0;
        m_left = WT;
      end
    end else if (m_firing) begin
      m_firing = 0;
      m_steps++;
      if (h) m_stopped = 1;
      else m_left = WT;
    end else if (m_fetching) begin
      if (fr) begin
        m_fetching = 0;
        m_firing = 1;
      end
    end else if (h) begin
      m_stopped = 1;
    end else begin
      m_left--;
      if (m_left == 0) m_fetching = 1;
    end
  endfunction

  function automatic logic [2:0] m_state();
    if (m_stopped) return S_HALT;
    if (m_firing) return S_STEP;
    if (m_fetching) return S_FETCH;
    return S_WAIT;
  endfunction

  initial begin
    int cyc;
    int scyc[$];
    int flen[$];
    int fcnt;
    int s0;

    // halt-during-FETCH sequence, run mode
    tbl[0]  = '{1, 0, 0, S_WAIT, 0, 0};
    tbl[1]  = '{1, 0, 0, S_WAIT, 0, 0};
    tbl[2]  = '{1, 0, 0, S_WAIT, 0, 0};
    tbl[3]  = '{1, 0, 0, S_FETCH, 1, 0};
    tbl[4]  = '{1, 1, 0, S_FETCH, 1, 0};
    tbl[5]  = '{1, 1, 1, S_STEP, 0, 1};
    tbl[6]  = '{1, 1, 0, S_HALT, 0, 0};
    tbl[7]  = '{1, 1, 0, S_HALT, 0, 0};
    tbl[8]  = '{1, 1, 1, S_HALT, 0, 0};
    tbl[9]  = '{1, 0, 0, S_WAIT, 0, 0};
    tbl[10] = '{1, 0, 0, S_WAIT, 0, 0};
    tbl[11] = '{1, 0, 0, S_WAIT, 0, 0};
    tbl[12] = '{1, 0, 0, S_WAIT, 0, 0};
    tbl[13] = '{1, 0, 0, S_FETCH, 1, 0};
    tbl[14] = '{1, 0, 1, S_STEP, 0, 1};
    tbl[15] = '{1, 0, 0, S_WAIT, 0, 0};

    // reset values
    @(negedge clock);
    chk("rst_fetch_req", 32'(fetch_req), 0);
    chk("rst_step", 32'(step), 0);
    chk("rst_state", 32'(state), 32'(S_WAIT));
`ifdef PIPE_STEP_COUNT_EN
    chk("rst_step_count", step_count, 0);
`endif
    do_reset();

    // table-driven vectors
    for (int i = 0; i < 16; i++) begin
      run_mode = tbl[i].rm;
      halt = tbl[i].h;
      fetch_ready = tbl[i].fr;
      @(negedge clock);
      chk($sformatf("tbl%0d_state", i), 32'(state), 32'(tbl[i].st));
      chk($sformatf("tbl%0d_freq", i), 32'(fetch_req),
          32'(tbl[i].freq));
      chk($sformatf("tbl%0d_step", i), 32'(step), 32'(tbl[i].stp));
    end

    // run mode, fetch_ready tied high: steps at 5, 11, 17
    halt = 0;
    run_mode = 1;
    fetch_ready = 1;
    do_reset();
    scyc.delete();
    for (int c = 1; c <= 20; c++) begin
      @(negedge clock);
      if (step) scyc.push_back(c);
`ifdef PIPE_STEP_COUNT_EN
      if (c == 18) chk("run_step_count", step_count, 3);
`endif
    end
    chk("run_nsteps", 32'(scyc.size()), 3);
    for (int k = 0; k < 3 && k < scyc.size(); k++)
      chk($sformatf("run_step%0d_cycle", k), 32'(scyc[k]),
          32'(5 + 6 * k));

    // run mode, fetch_ready 3 cycles after fetch_req rises
    fetch_ready = 0;
    do_reset();
    scyc.delete();
    flen.delete();
    fcnt = 0;
    for (int c = 1; c <= 34; c++) begin
      @(negedge clock);
      if (step) scyc.push_back(c);
      if (fetch_req) begin
        fcnt++;
      end else begin
        if (fcnt != 0) flen.push_back(fcnt);
        fcnt = 0;
      end
      fetch_ready = fetch_req && (fcnt == 3);
    end
    fetch_ready = 0;
    chk("slow_nsteps", 32'(scyc.size()), 4);
    if (scyc.size() > 0) chk("slow_first_step", 32'(scyc[0]), 7);
    for (int k = 1; k < scyc.size(); k++)
      chk($sformatf("slow_period%0d", k), 32'(scyc[k] - scyc[k-1]), 8);
    foreach (flen[k])
      chk($sformatf("slow_fetch_len%0d", k), 32'(flen[k]), 3);

    // reset pulsed mid-FETCH
    cyc = 0;
    while (!fetch_req && cyc < 20) begin
      @(negedge clock);
      cyc++;
    end
    chk("midfetch_reached", 32'(fetch_req), 1);
    reset = 1'b1;
    #1;
    chk("midrst_fetch_req", 32'(fetch_req), 0);
    chk("midrst_step", 32'(step), 0);
    chk("midrst_state", 32'(state), 32'(S_WAIT));
`ifdef PIPE_STEP_COUNT_EN
    chk("midrst_step_count", step_count, 0);
`endif
    @(negedge clock);
    reset = 1'b0;
    fetch_ready = 1;
    first_step(cyc);
    chk("midrst_resume_cycle", 32'(cyc), 5);

    // single-step: one clean press, then a glitch
    run_mode = 0;
    do_reset();
    repeat (4) @(negedge clock);
    s0 = nsteps;
    press_btn(6, 20);
    chk("press_one_step", 32'(nsteps - s0), 1);
    s0 = nsteps;
    press_btn(2, 20);
    chk("glitch_no_step", 32'(nsteps - s0), 0);
    chk("glitch_state", 32'(state), 32'(S_WAIT));

    // single-step: stalled fetch, two more presses -> one extra step
    fetch_ready = 0;
    s0 = nsteps;
    press_btn(6, 8);
    chk("stall_in_fetch", 32'(fetch_req), 1);
    press_btn(6, 8);
    press_btn(6, 8);
    chk("stall_no_step", 32'(nsteps - s0), 0);
    fetch_ready = 1;
    repeat (20) @(negedge clock);
    chk("stall_total_steps", 32'(nsteps - s0), 2);

    // randomized run-mode traffic against the model
    run_mode = 1;
    halt = 0;
    fetch_ready = 0;
    do_reset();
    m_init();
    for (int i = 0; i < 400; i++) begin
      m_advance(halt, fetch_ready);
      @(negedge clock);
      chk("rnd_state", 32'(state), 32'(m_state()));
      chk("rnd_step", 32'(step), 32'(m_firing));
      chk("rnd_fetch_req", 32'(fetch_req), 32'(m_fetching));
`ifdef PIPE_STEP_COUNT_EN
      chk("rnd_step_count", step_count, 32'(m_steps));
`endif
      if ($urandom_range(0, 9) == 0) halt = ~halt;
      fetch_ready = ($urandom_range(0, 2) == 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/pipeline_step_controller.md
# pipeline_step_controller

Sequences the CPU pipeline by generating the single-cycle `step` enable that advances `pc` and every pipeline register stage, on the same `clock` as the datapath. It replaces the free-running divided clock with an enable-based scheme. In run mode it issues one step every `WAIT_TIME` cycles. In single-step mode it issues one step per debounced button press. Before each step it handshakes with instruction memory so a step never latches a stale instruction.

## Interface
- `WAIT_TIME`, default 54000000: run-mode idle cycles between steps; minimum 2.
- `DEBOUNCE_CYCLES`, default 270000: cycles a button level must be stable before it is accepted; minimum 1.
- `clock  in  1`: the single clock; all logic is on its rising edge.
- `reset  in  1`: asynchronous, active-high.
- `run_mode  in  1`: 1 = free-run; 0 = single-step by button.
- `btn  in  1`: raw board button, active-low, asynchronous to `clock`.
- `halt  in  1`: level; while 1, no new step is started.
- `fetch_ready  in  1`: instruction memory output is valid for the current `pc`.
- `fetch_req  out  1`: requests an instruction read at the current `pc`.
- `step  out  1`: one-cycle enable for `pc` and all pipeline registers.
- `state  out  3`: current FSM state, for LEDs and debug.
- `step_count  out  32`: number of steps issued; present only with `PIPE_STEP_COUNT_EN`.

## Operation
- The FSM has four states: WAIT, FETCH, STEP, HALTED.
- **WAIT**
  - If `halt` is 1, go to HALTED.
  - Else if `run_mode` is 1: the counter increments each cycle. When it equals `WAIT_TIME-1`, clear it and go to FETCH.
  - Else (single-step): the counter is held at 0. If a button token is pending or arrives this cycle, consume it and go to FETCH.
- **FETCH**
  - `fetch_req` is 1.
  - When `fetch_ready` is 1, go to STEP.
  - `halt` is ignored here; a started step always completes.
- **STEP**
  - `step` is 1 for exactly this one cycle.
  - Next state is HALTED if `halt` is 1, else WAIT.
- **HALTED**
  - No outputs are asserted.
  - When `halt` goes to 0, go to WAIT with the counter cleared.
- **Button path**
  - A 2-flop synchronizer feeds the debouncer.
  - The accepted level changes only after the synchronized level has differed from it for `DEBOUNCE_CYCLES` consecutive cycles.
  - A 1→0 change of the accepted level (a press) produces a one-cycle press pulse.
- **Token**
  - One pending bit.
  - Set by a press pulse in any state when `run_mode` is 0.
  - Further presses while a token is pending are dropped.
  - Cleared on consumption, whenever `run_mode` is 1, and on reset.
- A `run_mode` change is sampled only in WAIT. Switching 1→0 clears the counter.

## Timing
- Reset values:
  - `fetch_req` = 0, `step` = 0.
  - `state` = WAIT, counter = 0, token = 0.
  - Debouncer accepted level = 1 (released).
  - `step_count` = 0.
- Run-mode step period is `WAIT_TIME + F + 1` cycles, where F ≥ 1 is the number of FETCH cycles.
- Single-step latency from the raw press edge to `step` is 2 (sync) + `DEBOUNCE_CYCLES` + 1 (pulse) + F + 1 cycles.
- Reset asserted mid-operation: all outputs take their reset values asynchronously. Any partial FETCH is abandoned.
- `fetch_ready` asserted in the same cycle `fetch_req` rises gives F = 1.
- `step_count` increments in the STEP cycle and wraps from 2^32−1 to 0.

## Configuration
- `PIPE_STEP_COUNT_EN` defined: the 32-bit `step_count` register and port exist.
- Not defined: the port and register are omitted. All other behaviour is identical.

## Structure
- A shared package `step_ctrl_pkg` holds:
  - the state encoding constants (WAIT=0, FETCH=1, STEP=2, HALTED=3);
  - the `state` width.
- One sub-module, `btn_debouncer`, contains the synchronizer, the debounce counter, the accepted level and the press-pulse output. Parameter: `DEBOUNCE_CYCLES`.
- The FSM, counter, token and step counter live in the top module.

## Test plan
All scenarios use `WAIT_TIME=4` and `DEBOUNCE_CYCLES=3`.
- Run mode, `fetch_ready` tied 1, reset released at cycle 0 → first `step` at cycle 5, then every 6 cycles; `step_count` = 3 after the third pulse.
- Run mode, `fetch_ready` 3 cycles after `fetch_req` rises → `fetch_req` high exactly 3 cycles; step period 8.
- Single-step, `btn` low for 6 cycles → exactly one `step`. A 2-cycle low glitch → no `step`.
- Single-step, `fetch_ready` held 0 while two further presses occur → exactly one extra `step` after the current one completes.
- `halt` raised during FETCH → that `step` still issues; `state` = HALTED and no steps follow. `halt` lowered → next `step` after 4 WAIT cycles plus FETCH.
- `reset` pulsed mid-FETCH → `fetch_req` = 0, `step` = 0, `state` = WAIT, `step_count` = 0 immediately; normal sequencing resumes.
